sobel_window_ctrl: RTL

- Sequences a 3x3 window filter datapath (pipelined, enable-gated, fixed latency) for a raster pixel stream.
- Holds two line buffers and a 3x3 register window, and drives the filter's nine window inputs and its enable.
- Tracks which filter results are valid interior pixels and drains the filter pipeline at end of frame.
- Sits between the pixel source and the filter, with a valid/ready handshake on both sides.

---
 rtl/sobel_window_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// Window controller for a pipelined 3x3 filter: two line buffers, a 3x3 window,
// enable sequencing, interior-result tagging and end-of-frame pipeline drain.
module sobel_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FILT_LAT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [9*DATA_WIDTH-1:0] win_bus,
  output logic                    filt_en,
  input  logic [DATA_WIDTH-1:0]   filt_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_eof,
  output logic                    busy
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NRES = (IMG_W - 2) * (IMG_H - 2);
  localparam int NW   = $clog2(NRES + 1);
  localparam int FW   = $clog2(FILT_LAT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [NW-1:0] RES_LAST = NW'(NRES - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(FILT_LAT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic                    rdy_q;
  logic                    pend_q;
  logic                    cur_tag_q;
  logic [FILT_LAT-1:0]     tag_sr_q, tag_sr_d;
  logic [CW-1:0]           col_q, col_d, pix_col;
  logic [RW-1:0]           row_q, row_d, pix_row;
  logic [FW-1:0]           flush_cnt_q;
  logic [NW-1:0]           res_cnt_q;
  logic                    out_valid_q;
  logic                    out_eof_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [DATA_WIDTH-1:0]   win_q [9];
  logic [DATA_WIDTH-1:0]   lb0_q [IMG_W];
  logic [DATA_WIDTH-1:0]   lb1_q [IMG_W];

  logic stall, accept, restart, process, last_pix, tag_new;
  logic fire, capture, flush_done;

  always_comb begin
    stall      = out_valid_q & ~out_ready;
    in_ready   = rdy_q & ~stall;
    accept     = in_valid & in_ready;
    restart    = accept & in_sof;
    // IDLE drops pixels until a start-of-frame arrives
    process    = accept & (in_sof | (state_q == RUN));
    pix_col    = restart ? '0 : col_q;
    pix_row    = restart ? '0 : row_q;
    last_pix   = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    tag_new    = (pix_row >= RW'(2)) && (pix_col >= CW'(2));
    fire       = pend_q & ~stall;
    capture    = fire & tag_sr_q[FILT_LAT-1] & ~restart;
    flush_done = fire && (state_q == FLUSH) && (flush_cnt_q == FL_LAST);
    filt_en    = fire;
  end

  always_comb begin
    col_d = pix_col + 1'b1;
    row_d = pix_row;
    if (pix_col == COL_LAST) begin
      col_d = '0;
      row_d = (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (process)         state_d = last_pix ? FLUSH : RUN;
    else if (flush_done) state_d = IDLE;
  end

  always_comb begin
    tag_sr_d    = tag_sr_q << 1;
    tag_sr_d[0] = cur_tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      pend_q      <= 1'b0;
      cur_tag_q   <= 1'b0;
      tag_sr_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      flush_cnt_q <= '0;
      res_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FLUSH);

      if (process) begin
        col_q     <= col_d;
        row_q     <= row_d;
        cur_tag_q <= tag_new;
        pend_q    <= 1'b1;
        win_q[0]  <= win_q[1];
        win_q[1]  <= win_q[2];
        win_q[2]  <= lb1_q[pix_col];
        win_q[3]  <= win_q[4];
        win_q[4]  <= win_q[5];
        win_q[5]  <= lb0_q[pix_col];
        win_q[6]  <= win_q[7];
        win_q[7]  <= win_q[8];
        win_q[8]  <= in_data;
      end else if (fire) begin
        // drain pulses after the last pixel carry a zero tag
        cur_tag_q <= 1'b0;
        if (state_q != FLUSH || flush_done) pend_q <= 1'b0;
      end

      if (process && last_pix)               flush_cnt_q <= '0;
      else if (fire && (state_q == FLUSH))   flush_cnt_q <= flush_cnt_q + 1'b1;

      if (restart)   tag_sr_q <= '0;
      else if (fire) tag_sr_q <= tag_sr_d;

      if (capture) begin
        out_valid_q <= 1'b1;
        out_data_q  <= filt_data;
        out_eof_q   <= (res_cnt_q == RES_LAST);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_eof_q   <= 1'b0;
      end

      if (restart)      res_cnt_q <= '0;
      else if (capture) res_cnt_q <= (res_cnt_q == RES_LAST) ? '0 : res_cnt_q + 1'b1;
    end
  end

  // Line buffers need no reset; their contents are rewritten before use
  always_ff @(posedge clk) begin
    if (process) begin
      lb1_q[pix_col] <= lb0_q[pix_col];
      lb0_q[pix_col] <= in_data;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_win
    assign win_bus[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eof   = out_eof_q;
  assign busy      = (state_q != IDLE);

endmodule
